wb_bus_arbiter: RTL

- Shares the single external Wishbone master port of the Grande_Risco5 top between three requesters: I-cache line fills (read-only), D-cache fills/write-backs, and uncached peripheral accesses (core data port, addr[31]=1).
- Replaces the combinational cache multiplexer and peripheral lock logic with registered round-robin arbitration, one outstanding bus cycle at a time, and a watchdog timeout that returns an error instead of hanging the core.

---
 rtl/wb_bus_arbiter_pkg.sv | 21 ++
 rtl/wb_bus_arbiter_rr_pick.sv | 28 ++
 rtl/wb_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared constants and types for the Grande_Risco5 external bus arbiter.
package grande_risco5_bus_pkg;

    // Number of requesters sharing the external Wishbone port.
    localparam int unsigned NUM_MASTERS = 3;
    // Width of a requester index.
    localparam int unsigned MST_IDX_W   = 2;

    // Requester indices.
    localparam int unsigned MST_ICACHE  = 0;
    localparam int unsigned MST_DCACHE  = 1;
    localparam int unsigned MST_PERIPH  = 2;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUS,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', with wrap.
module rr_pick #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   valid,
    output logic [IDX_W-1:0]       grant
);

    logic [IDX_W-1:0] sel;

    // Walk the requesters starting just after the previous winner.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        sel   = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            sel = IDX_W'((32'(last) + off) % NUM_MASTERS);
            if (!valid && req[sel]) begin
                valid = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the icache,
// dcache and uncached peripheral requesters, with a no-ack watchdog.
module wb_bus_arbiter
    import grande_risco5_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            req_i,
    input  logic [NUM_MASTERS-1:0]            we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_MASTERS-1:0]            rsp_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              err_o,
    output logic                              cyc_o,
    output logic                              stb_o,
    output logic                              we_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    input  logic                              ack_i,
    input  logic [DATA_WIDTH-1:0]             data_i
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic [MST_IDX_W-1:0]   grant_q, grant_d;
    logic [MST_IDX_W-1:0]   last_q,  last_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   we_q,    we_d;
    logic                   cyc_q,   cyc_d;
    logic [NUM_MASTERS-1:0] rsp_q,   rsp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q,   err_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic                   pick_valid;
    logic [MST_IDX_W-1:0]   pick_grant;
    logic [NUM_MASTERS-1:0] we_eff;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

    // Unpack the per-master address/data buses.
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign addr_arr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // The icache is read-only; its write enable input is ignored.
    assign we_eff = {we_i[NUM_MASTERS-1:1], 1'b0};

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (MST_IDX_W)
    ) u_rr_pick (
        .req   (req_i),
        .last  (last_q),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    // Next-state and registered-output logic for grant, bus cycle and response.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rsp_d   = '0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    last_d  = pick_grant;
                    addr_d  = addr_arr[pick_grant];
                    wdata_d = wdata_arr[pick_grant];
                    we_d    = we_eff[pick_grant];
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_BUS;
                end
            end
            ARB_BUS: begin
                if (ack_i) begin
                    cyc_d          = 1'b0;
                    we_d           = 1'b0;
                    rdata_d        = data_i;
                    rsp_d[grant_q] = 1'b1;
                    err_d          = 1'b0;
                    state_d        = ARB_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    cyc_d          = 1'b0;
                    we_d           = 1'b0;
                    rdata_d        = '0;
                    rsp_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = ARB_RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State register; reset leaves last grant on periph so icache wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= MST_IDX_W'(MST_PERIPH);
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rsp_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign data_o  = wdata_q;
    assign rsp_o   = rsp_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
